// File: rtl/pnm_result_writer.sv
// Commits the PNM result stream to paged memory through a one-hot per-page write port.
// Latency: input sampled at edge N reaches the output register at N+1; the write retires on the first mem_ready edge after that.
// Backpressure: mem_ready stalls the output register, and a FIFO absorbs the stall; input that arrives while full is dropped and flagged.

module pnm_rw_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               dat_i,
    output logic [W-1:0]               dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= dat_i;
    end

    assign dat_o   = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

module pnm_result_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int Address_Size = 16,
    parameter int NUM_PAGES    = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        wr_start,
    input  logic                                        flush,
    input  logic                                        in_valid,
    input  logic [Address_Size-1:0]                     in_addr,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    input  logic                                        mem_ready,
    output logic [NUM_PAGES-1:0]                        mem_we,
    output logic [Address_Size-$clog2(NUM_PAGES)-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]                       mem_wdata,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        overflow,
    output logic [Address_Size-1:0]                     write_count
);
    localparam int PAGE_ADDR_BITS = $clog2(NUM_PAGES);
    localparam int IN_W           = Address_Size - PAGE_ADDR_BITS;
    localparam int CW             = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [PAGE_ADDR_BITS-1:0] page;
        logic [IN_W-1:0]           addr;
        logic [DATA_WIDTH-1:0]     data;
    } ent_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    busy_q, done_q, overflow_q;
    logic [Address_Size-1:0] wcnt_q;
    logic [NUM_PAGES-1:0]    mem_we_q;
    logic [IN_W-1:0]         mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    ent_t          push_ent, head;
    logic [CW-1:0] fifo_cnt;
    logic          accepting, out_vld, wr_done, fifo_empty, fifo_full;
    logic          pop, push_req, push, drop;

    assign push_ent.page = in_addr[Address_Size-1 -: PAGE_ADDR_BITS];
    assign push_ent.addr = in_addr[IN_W-1:0];
    assign push_ent.data = in_data;

    assign accepting  = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
    assign out_vld    = |mem_we_q;
    assign wr_done    = out_vld && mem_ready;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    // Refill the output register whenever it is free or retiring this edge.
    assign pop        = !fifo_empty && (!out_vld || wr_done);
    assign push_req   = in_valid && accepting;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push;

    pnm_rw_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .dat_i   (push_ent),
        .dat_o   (head),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (pop) begin
            mem_we_q    <= NUM_PAGES'(1) << head.page;
            mem_addr_q  <= head.addr;
            mem_wdata_q <= head.data;
        end else if (wr_done) begin
            mem_we_q    <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            if (drop)    overflow_q <= 1'b1;
            if (wr_done) wcnt_q     <= wcnt_q + Address_Size'(1);
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (wr_start) begin
                        state_q    <= ST_ACTIVE;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        wcnt_q     <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (flush) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // A trailing result arriving now keeps the job open.
                    if (fifo_empty && !out_vld && !in_valid) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign write_count = wcnt_q;
endmodule

// File: tb/tb_pnm_result_writer.sv
// Randomised and directed bench for pnm_result_writer with a queue-based reference model and write scoreboard.
module tb_pnm_result_writer;
    localparam int DW = 32;
    localparam int AS = 16;
    localparam int NP = 64;
    localparam int FD = 4;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_start = 1'b0, flush = 1'b0, in_valid = 1'b0, mem_ready = 1'b0;
    logic [AS-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic [NP-1:0] mem_we;
    logic [IW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy, done, overflow;
    logic [AS-1:0] write_count;

    always #5 clk = ~clk;

    pnm_result_writer #(
        .DATA_WIDTH(DW), .Address_Size(AS), .NUM_PAGES(NP), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .flush(flush),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .overflow(overflow), .write_count(write_count)
    );

    typedef struct {
        int          page;
        int          addr;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        m_fifo[$];
    ent_t        m_out;
    bit          m_out_v;
    int          m_state;  // 0 idle, 1 active, 2 drain, 3 done
    logic [15:0] m_cnt;
    bit          m_ovf;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fifo.delete();
        m_out_v = 0;
        m_state = 0;
        m_cnt   = 0;
        m_ovf   = 0;
    endtask

    // Predicts the effect of the coming clock edge given the inputs just driven.
    task automatic model_step();
        bit   complete, acc, pop, push, fifo_was_empty, out_was_v;
        ent_t e;
        fifo_was_empty = (m_fifo.size() == 0);
        out_was_v      = m_out_v;
        complete = m_out_v && mem_ready;
        acc      = (m_state == 1 || m_state == 2) && in_valid;
        pop      = !fifo_was_empty && (!m_out_v || complete);
        push     = acc && (m_fifo.size() < FD || pop);
        if (acc && !push) m_ovf = 1;
        if (complete) m_cnt = m_cnt + 16'd1;
        if (pop) begin
            m_out   = m_fifo.pop_front();
            m_out_v = 1;
        end else if (complete) begin
            m_out_v = 0;
        end
        if (push) begin
            e.page = int'(in_addr) / 1024;
            e.addr = int'(in_addr) % 1024;
            e.data = in_data;
            m_fifo.push_back(e);
            exp_q.push_back(e);
        end
        case (m_state)
            0, 3: if (wr_start) begin m_state = 1; m_cnt = 0; m_ovf = 0; end
            1: if (flush) m_state = 2;
            2: if (fifo_was_empty && !out_was_v && !in_valid) m_state = 3;
            default: m_state = 0;
        endcase
    endtask

    task automatic check_outputs();
        chk("mem_we", mem_we, m_out_v ? (64'd1 << m_out.page) : 64'd0);
        if (m_out_v) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_out.addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_out.data));
        end
        chk("busy", 64'(busy), 64'(m_state == 1 || m_state == 2));
        chk("done", 64'(done), 64'(m_state == 3));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("write_count", 64'(write_count), 64'(m_cnt));
    endtask

    task automatic step(input logic v, input logic [15:0] a, input logic [31:0] d,
                        input logic rdy, input logic st, input logic fl);
        @(posedge clk);
        #1;
        check_outputs();
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        mem_ready = rdy;
        wr_start  = st;
        flush     = fl;
        model_step();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 16'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (m_state != 3 && n < 100) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 0; wr_start = 0; flush = 0; mem_ready = 0;
        model_reset();
        #1;
        chk("rst_mem_we", mem_we, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_write_count", 64'(write_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every retiring write is matched against arrival order.
    logic [NP-1:0] prev_we;
    logic [IW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    bit            prev_stall = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_we_stable", mem_we, prev_we);
                chk("stall_addr_stable", 64'(mem_addr), 64'(prev_addr));
                chk("stall_data_stable", 64'(mem_wdata), 64'(prev_wdata));
            end
            if (mem_we != '0 && mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_write", mem_we, 64'd0);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("sb_page", mem_we, 64'd1 << e.page);
                    chk("sb_addr", 64'(mem_addr), 64'(e.addr));
                    chk("sb_data", 64'(mem_wdata), 64'(e.data));
                end
                prev_stall = 0;
            end else begin
                prev_stall = (mem_we != '0);
            end
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    initial begin
        do_reset();

        // Inputs ignored in IDLE
        step(1'b1, 16'h1234, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("idle_no_write", mem_we, 64'd0);

        // Single write and its latency
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h0C05, 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("lat_in_fifo", mem_we, 64'd0);
        idle(1'b1);
        chk("lat_we", mem_we, 64'h8);
        chk("lat_addr", 64'(mem_addr), 64'h005);
        chk("lat_data", 64'(mem_wdata), 64'h3F80_0000);
        idle(1'b1);
        chk("single_count", 64'(write_count), 64'd1);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_done();

        // Burst of 8 consecutive addresses
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 16'h7FFC + 16'(i), $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_done();
        chk("burst_count", 64'(write_count), 64'd8);
        chk("burst_overflow", 64'(overflow), 64'd0);

        // Stall: five buffered, sixth dropped
        step(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'(($urandom)), $urandom, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("stall_no_overflow", 64'(overflow), 64'd0);
        step(1'b1, 16'hFFFF, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("stall_overflow", 64'(overflow), 64'd1);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_done();
        chk("stall_count", 64'(write_count), 64'd5);
        chk("stall_overflow_sticky", 64'(overflow), 64'd1);

        // Full FIFO with simultaneous push and pop
        step(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("start_clears_overflow", 64'(overflow), 64'd1);
        idle(1'b0);
        chk("overflow_cleared", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'(($urandom)), $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'(($urandom)), $urandom, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("full_pushpop_overflow", 64'(overflow), 64'd0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_done();
        chk("full_count", 64'(write_count), 64'd8);

        // flush with in_valid, then a trailing input in DRAIN
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h0400, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'hFC00, 32'hA5A5_0002, 1'b1, 1'b0, 1'b0);
        wait_done();
        chk("drain_count", 64'(write_count), 64'd2);
        chk("drain_busy", 64'(busy), 64'd0);

        // Randomised jobs
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 16'h0, 32'h0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            for (int c = 0; c < 40; c++)
                step(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);
            step(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 1'b1, 1'b0, 1'b1);
            for (int c = 0; c < 4; c++)
                step(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                     1'($urandom_range(0, 1)), 1'b0, 1'b0);
            wait_done();
        end

        // Reset mid-burst, then a clean job
        step(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'(($urandom)), $urandom, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h2001, 32'h0000_0C0D, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h2002, 32'h0000_0E0F, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_done();
        chk("post_reset_count", 64'(write_count), 64'd2);

        repeat (3) idle(1'b1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
